// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes release of the async rst and releases memory,
// pipeline and PC resets in fixed staggered order; also services soft resets.
module rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 soft_rst_req,
  output logic                 rst_mem,
  output logic                 rst_pipe,
  output logic                 rst_pc,
  output logic                 sys_ready,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [7:0]           soft_rst_cnt
);

  localparam int MAX_WAIT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_HOLD,
    S_REL_MEM,
    S_REL_PIPE,
    S_RUN
  } state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          wait_reg;

  // Only the last synchronizer stage observes the release of rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_SYNC;
      wait_reg     <= '0;
      rst_mem      <= 1'b1;
      rst_pipe     <= 1'b1;
      rst_pc       <= 1'b1;
      sys_ready    <= 1'b0;
      cycle_cnt    <= '0;
      soft_rst_cnt <= '0;
    end else begin
      // Counts on the registered sys_ready, so the capture edge of a soft reset still counts.
      if (sys_ready) begin
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      end
      case (state_reg)
        S_SYNC: begin
          if (sync_reg[SYNC_STAGES-1]) begin
            state_reg <= S_HOLD;
            wait_reg  <= '0;
          end
        end
        S_HOLD: begin
          if (wait_reg == HOLD_LAST) begin
            rst_mem   <= 1'b0;
            state_reg <= S_REL_MEM;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + CW'(1);
          end
        end
        S_REL_MEM: begin
          if (wait_reg == STAG_LAST) begin
            rst_pipe  <= 1'b0;
            state_reg <= S_REL_PIPE;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + CW'(1);
          end
        end
        S_REL_PIPE: begin
          if (wait_reg == STAG_LAST) begin
            rst_pc    <= 1'b0;
            sys_ready <= 1'b1;
            state_reg <= S_RUN;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + CW'(1);
          end
        end
        S_RUN: begin
          // Soft reset re-enters the hold phase directly; the synchronizer is already settled.
          if (soft_rst_req) begin
            rst_mem   <= 1'b1;
            rst_pipe  <= 1'b1;
            rst_pc    <= 1'b1;
            sys_ready <= 1'b0;
            state_reg <= S_HOLD;
            wait_reg  <= '0;
            if (soft_rst_cnt != 8'hFF) begin
              soft_rst_cnt <= soft_rst_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_reg <= S_SYNC;
          wait_reg  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: default instance for release timing and
// soft reset, a 4-bit counter instance for wrap and soft-count saturation.
module tb_rst_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int STAG = 2;
  localparam int M    = 1 + SYNC + HOLD;
  localparam int P    = M + STAG;
  localparam int C    = P + STAG;
  localparam int SH   = HOLD;
  localparam int SP   = HOLD + STAG;
  localparam int SC   = HOLD + 2 * STAG;

  typedef struct packed {
    logic        mem;
    logic        pipe;
    logic        pc;
    logic        ready;
    logic [31:0] cnt;
    logic [7:0]  scnt;
  } exp_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic [7:0] scnt;
  } exp2_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        soft_rst_req = 1'b0;
  logic        rst_mem, rst_pipe, rst_pc, sys_ready;
  logic [31:0] cycle_cnt;
  logic [7:0]  soft_rst_cnt;

  logic        rst2 = 1'b0;
  logic        soft_rst_req2 = 1'b0;
  logic        rst_mem2, rst_pipe2, rst_pc2, sys_ready2;
  logic [3:0]  cycle_cnt2;
  logic [7:0]  soft_rst_cnt2;

  int checks = 0;
  int errors = 0;

  exp_t  sb[$];
  exp2_t sb2[$];

  rst_sequencer #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
    .rst_mem(rst_mem), .rst_pipe(rst_pipe), .rst_pc(rst_pc), .sys_ready(sys_ready),
    .cycle_cnt(cycle_cnt), .soft_rst_cnt(soft_rst_cnt)
  );

  rst_sequencer #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst2), .soft_rst_req(soft_rst_req2),
    .rst_mem(rst_mem2), .rst_pipe(rst_pipe2), .rst_pc(rst_pc2), .sys_ready(sys_ready2),
    .cycle_cnt(cycle_cnt2), .soft_rst_cnt(soft_rst_cnt2)
  );

  always #5 clk = ~clk;

  // Expected outputs k edges into a release whose three resets fall at edges m, p, c.
  function automatic exp_t rel_exp(int k, int m, int p, int c, logic [31:0] cnt0, logic [7:0] sc);
    exp_t e;
    e.mem   = (k < m);
    e.pipe  = (k < p);
    e.pc    = (k < c);
    e.ready = (k >= c);
    e.cnt   = (k > c) ? cnt0 + 32'(k - c) : cnt0;
    e.scnt  = sc;
    return e;
  endfunction

  // Ordering invariant on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    checks++;
    if ((rst_mem && !rst_pipe) || (rst_pipe && !rst_pc) || (sys_ready !== ~rst_pc)) begin
      errors++;
      $display("FAIL invariant t=%0t: mem=%b pipe=%b pc=%b ready=%b", $time, rst_mem, rst_pipe, rst_pc, sys_ready);
    end
    checks++;
    if ((rst_mem2 && !rst_pipe2) || (rst_pipe2 && !rst_pc2) || (sys_ready2 !== ~rst_pc2)) begin
      errors++;
      $display("FAIL invariant2 t=%0t: mem=%b pipe=%b pc=%b ready=%b", $time, rst_mem2, rst_pipe2, rst_pc2, sys_ready2);
    end
  end

  task automatic test_reset();
    exp_t obs, e;
    int   n;
    #1;
    obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
    e   = {1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 8'd0};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, e);
    end
    #29;
    rst = 1'b0;
    for (int k = 1; k <= C + 3; k++) sb.push_back(rel_exp(k, M, P, C, 32'd0, 8'd0));
    n = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      n++;
      e   = sb.pop_front();
      obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL power_on edge %0d t=%0t: got %h want %h", n, $time, obs, e);
      end
    end
    $display("test_reset: power-on release checked through edge %0d", n);
  endtask

  task automatic test_soft_reset();
    exp_t obs, e;
    int   n;
    for (int i = 0; i < 200; i++) begin
      if (cycle_cnt == 32'd19) break;
      @(posedge clk); #1;
    end
    checks++;
    if (cycle_cnt !== 32'd19) begin
      errors++;
      $display("FAIL soft_wait: cycle_cnt=%0d want 19", cycle_cnt);
    end
    soft_rst_req = 1'b1;
    sb.push_back({1'b1, 1'b1, 1'b1, 1'b0, 32'd20, 8'd1});
    for (int j = 1; j <= SC + 3; j++) sb.push_back(rel_exp(j, SH, SP, SC, 32'd20, 8'd1));
    n = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      soft_rst_req = 1'b0;
      e   = sb.pop_front();
      obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL soft_reset N+%0d t=%0t: got %h want %h", n, $time, obs, e);
      end
      n++;
    end
    $display("test_soft_reset: one soft reset checked over %0d edges", n);
  endtask

  task automatic test_rst_wins();
    exp_t obs, e;
    int   n;
    #3;
    rst = 1'b1;
    soft_rst_req = 1'b1;
    #1;
    e   = {1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 8'd0};
    obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_wins_async: got %h want %h", obs, e);
    end
    @(posedge clk); #1;
    obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_wins_edge: got %h want %h", obs, e);
    end
    soft_rst_req = 1'b0;
    #4;
    rst = 1'b0;
    for (int k = 1; k <= C + 1; k++) sb.push_back(rel_exp(k, M, P, C, 32'd0, 8'd0));
    n = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      n++;
      e   = sb.pop_front();
      obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rst_wins_release edge %0d: got %h want %h", n, obs, e);
      end
    end
    $display("test_rst_wins: rst with soft request gave full reset, release checked");
  endtask

  task automatic test_mid_reset();
    exp_t obs, e;
    int   n;
    for (int i = 0; i < 50; i++) begin
      if (rst_mem === 1'b0 && rst_pipe === 1'b1) break;
      @(posedge clk); #1;
      if (i == 0) begin
        rst = 1'b1;
        #10;
        rst = 1'b0;
      end
    end
    checks++;
    if (!(rst_mem === 1'b0 && rst_pipe === 1'b1)) begin
      errors++;
      $display("FAIL mid_wait: mem=%b pipe=%b want mem=0 pipe=1", rst_mem, rst_pipe);
    end
    #2;
    rst = 1'b1;
    #1;
    e   = {1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 8'd0};
    obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_async: got %h want %h", obs, e);
    end
    #2;
    rst = 1'b0;
    for (int k = 1; k <= C + 2; k++) sb.push_back(rel_exp(k, M, P, C, 32'd0, 8'd0));
    n = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      n++;
      e   = sb.pop_front();
      obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_release edge %0d: got %h want %h", n, obs, e);
      end
    end
    $display("test_mid_reset: short pulse during memory release restarted full sequence");
  endtask

  task automatic test_ignored_req();
    exp_t obs, e;
    int   n;
    #4;
    rst = 1'b1;
    soft_rst_req = 1'b1;
    #10;
    rst = 1'b0;
    for (int k = 1; k <= C; k++) sb.push_back(rel_exp(k, M, P, C, 32'd0, 8'd0));
    sb.push_back({1'b1, 1'b1, 1'b1, 1'b0, 32'd1, 8'd1});
    for (int j = 1; j <= SC + 2; j++) sb.push_back(rel_exp(j, SH, SP, SC, 32'd1, 8'd1));
    n = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      n++;
      if (n == C + 1) soft_rst_req = 1'b0;
      e   = sb.pop_front();
      obs = {rst_mem, rst_pipe, rst_pc, sys_ready, cycle_cnt, soft_rst_cnt};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ignored_req edge %0d: got %h want %h", n, obs, e);
      end
    end
    $display("test_ignored_req: held request accepted once in RUN only");
  endtask

  task automatic test_saturation();
    exp2_t obs, e;
    #4;
    rst2 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sys_ready2 === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++;
    if (sys_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_release: sys_ready2=%b want 1", sys_ready2);
    end
    for (int i = 1; i <= 300; i++) begin
      sb2.push_back({4'(i % 16), 8'((i > 255) ? 255 : i)});
      soft_rst_req2 = 1'b1;
      @(posedge clk); #1;
      soft_rst_req2 = 1'b0;
      e   = sb2.pop_front();
      obs = {cycle_cnt2, soft_rst_cnt2};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL saturation req %0d: got cnt=%0d scnt=%0d want cnt=%0d scnt=%0d",
                 i, obs.cnt, obs.scnt, e.cnt, e.scnt);
      end
      for (int w = 0; w < 50; w++) begin
        if (sys_ready2 === 1'b1) break;
        @(posedge clk); #1;
      end
      if (sys_ready2 !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL sat_timeout req %0d: sys_ready2 never returned", i);
        break;
      end
    end
    $display("test_saturation: 300 soft resets, soft_rst_cnt2=%0d cycle_cnt2=%0d", soft_rst_cnt2, cycle_cnt2);
  endtask

  initial begin
    rst  = 1'b1;
    rst2 = 1'b1;
    test_reset();
    test_soft_reset();
    test_rst_wins();
    test_mid_reset();
    test_ignored_req();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Reset-consumer end of the SOC's clock/reset interface. It takes the bench-driven asynchronous active-high `rst` and synchronizes its release.
- It releases reset to the MIPS_CPU subsystems in a fixed order: data/instruction memory first, then pipeline registers (IF/ID/EX/MEM/WB), then the PC.
- It also services a CPU/debug soft-reset request and provides a run-cycle counter for simulation checks.
- It sits at the SOC top, between the external `clk`/`rst` pins and all internal reset nets.

Parameters:
- SYNC_STAGES, 2, depth of the reset-release synchronizer (legal: ≥2).
- HOLD_CYCLES, 4, cycles all resets stay asserted after synchronized release or soft reset (legal: ≥1).
- STAGGER, 2, cycles between successive domain releases (legal: ≥1).
- CNT_WIDTH, 32, width of cycle_cnt.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset (1'b1 = ENABLE).
- soft_rst_req  in  1  synchronous soft-reset request, level-sampled.
- rst_mem  out  1  active-high reset to instruction/data memory.
- rst_pipe  out  1  active-high reset to pipeline registers and regfile.
- rst_pc  out  1  active-high reset to the PC/fetch unit.
- sys_ready  out  1  high when every domain is out of reset.
- cycle_cnt  out  CNT_WIDTH  count of clock cycles with sys_ready=1.
- soft_rst_cnt  out  8  number of soft resets accepted, saturating.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous, active-high. One always-block family is sensitive to `posedge clk or posedge rst`.
- Reset values (while rst=1, effective immediately, no clock needed):
  - rst_mem = rst_pipe = rst_pc = 1.
  - sys_ready = 0, cycle_cnt = 0, soft_rst_cnt = 0.
  - Synchronizer cleared to all-0; state = S_SYNC.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Synchronizer: shift register of SYNC_STAGES bits, shifting in 1 each edge once rst=0. Its last stage is the only consumer of the rst release.
- States:
  - S_SYNC: stay until the last sync stage = 1; then go to S_HOLD with hold counter = 0.
  - S_HOLD: count HOLD_CYCLES cycles. At the edge completing cycle HOLD_CYCLES, rst_mem <= 0 and go to S_REL_MEM.
  - S_REL_MEM: after STAGGER cycles, rst_pipe <= 0 and go to S_REL_PIPE.
  - S_REL_PIPE: after STAGGER cycles, rst_pc <= 0, sys_ready <= 1 and go to S_RUN.
  - S_RUN: stay until soft_rst_req or rst.
- Hard-release timing: counting edge 1 as the first rising edge after rst falls:
  - rst_mem falls at edge 1+SYNC_STAGES+HOLD_CYCLES (default edge 7).
  - rst_pipe falls STAGGER edges later (edge 9).
  - rst_pc and sys_ready change STAGGER edges after that (edge 11).
- Soft reset:
  - Sampled only in S_RUN. If soft_rst_req=1 at edge N:
    - At edge N: rst_mem = rst_pipe = rst_pc = 1 and sys_ready = 0.
    - State goes to S_HOLD, bypassing the synchronizer.
    - soft_rst_cnt increments, saturating at 255.
  - The release sequence then follows: rst_mem falls at N+HOLD_CYCLES, rst_pipe at +STAGGER, rst_pc/sys_ready at +STAGGER again.
  - soft_rst_req in any other state is ignored, with no count and no restart.
  - A request held high re-triggers on every edge at which the block is in S_RUN.
- cycle_cnt:
  - Increments by 1 on every edge where sys_ready=1 (registered value), wrapping modulo 2^CNT_WIDTH.
  - Holds during a soft reset; it is not cleared.
  - Cleared only by rst.
- Ordering invariant, all states: rst_mem ≤ rst_pipe ≤ rst_pc in release order. rst_pipe is never 0 while rst_mem=1, and rst_pc is never 0 while rst_pipe=1. sys_ready = ~rst_pc at all times.
- rst asserted mid-sequence or mid-RUN aborts everything asynchronously to reset values. The sequence restarts from S_SYNC on the next release.
- rst and soft_rst_req simultaneous: rst wins and soft_rst_cnt stays 0.
- A rst pulse shorter than a clock period still fully resets the block and restarts the full sync + hold sequence.

Test Plan:
- Power-on, 10 ns clock starting low (edges at 5, 15, 25, 35 ns …), rst=1 from 0 ns released at 30 ns, defaults:
  - rst_mem falls at 95 ns, rst_pipe at 115 ns.
  - rst_pc falls and sys_ready rises at 135 ns; cycle_cnt = 1 after the 145 ns edge.
- Soft reset: in RUN with cycle_cnt=20, pulse soft_rst_req for one cycle captured at edge N:
  - All three resets are high and sys_ready=0 right after edge N.
  - rst_mem falls at N+4, rst_pipe at N+6, rst_pc at N+8.
  - soft_rst_cnt=1; cycle_cnt holds 20 throughout, then resumes at 21.
- Mid-sequence hard reset: assert rst 3 ns during S_REL_MEM (rst_mem=0, rst_pipe=1):
  - rst_mem returns to 1 immediately, without waiting for an edge.
  - After release the full default timing repeats (edge 7/9/11).
- Ignored request: hold soft_rst_req=1 continuously from power-on, drop it 1 cycle after sys_ready rises:
  - No effect before RUN.
  - Exactly one soft reset is accepted (soft_rst_cnt=1), then a normal release follows.
- Saturation/wrap: CNT_WIDTH=4 and 300 soft resets:
  - cycle_cnt wraps 15→0.
  - soft_rst_cnt stops at 255.
- Assertion bench, all scenarios: ordering invariant holds and sys_ready == ~rst_pc on every edge.
